spi_pin_conditioner: RTL and testbench
======================================

Name: spi_pin_conditioner

Overview:
- Upstream front end of the SPI memory; sits between the raw SPI pins and the memory FSM and shift register.
- Synchronizes, glitch-filters and edge-detects sclk, cs and mosi into the system clock domain.
- Emits one-cycle edge strobes plus a per-frame bit count, so downstream logic runs on clean, single-cycle events.

Parameters:
- WAIT, 3, consecutive stable clk cycles a synchronized input must differ from the conditioned value before the conditioned value updates; legal range 1..255.
- CNT_W, 4, width of bit_count; the count wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk_raw  input  1  asynchronous SPI clock pin.
- cs_raw  input  1  asynchronous chip-select pin, active low.
- mosi_raw  input  1  asynchronous MOSI pin.
- sclk_c  output  1  conditioned sclk level.
- cs_c  output  1  conditioned cs level.
- mosi_c  output  1  conditioned mosi level.
- sclk_rise  output  1  one-cycle strobe on a conditioned sclk 0->1 change.
- sclk_fall  output  1  one-cycle strobe on a conditioned sclk 1->0 change.
- cs_fall  output  1  one-cycle frame-start strobe.
- cs_rise  output  1  one-cycle frame-end strobe.
- bit_count  output  CNT_W  sclk rising edges seen since the current frame start.

Behaviour:
- Reset values: sclk_c=0, cs_c=1, mosi_c=0, all strobes 0, bit_count=0.
  - Both sync flops per channel reset to the same idle value as the channel's conditioned output (cs channel =1).
  - Per-channel filter counters reset to 0.
- Reset asserted mid-frame: every register takes its reset value at the next edge. No strobe fires that edge, including a cs_c 0->1 caused by reset.
- Sync stage, per channel: two flops, sync1<=raw, sync2<=sync1.
- Filter, per channel, evaluated each edge:
  - sync2==cond: cnt<=0.
  - else if cnt==WAIT-1: cond<=sync2, cnt<=0, and the matching edge strobe is set for exactly the next cycle.
  - else: cnt<=cnt+1.
- Glitch handling: an input that reverts before WAIT consecutive differing samples clears cnt and causes no change.
- Latency: a raw change held stable changes cond at clock edge WAIT+2 after the first edge that samples it. Example: WAIT=3 gives 5 edges.
- Strobes are registered and high for exactly one cycle. They coincide with the first cycle cond shows its new value.
- Channels are filtered independently. Simultaneous events on different channels all strobe in the same cycle.
- bit_count, evaluated each edge using the values being loaded this edge:
  - cs_fall being set: bit_count<=0. This wins over a simultaneous sclk_rise, which is not counted.
  - else sclk_rise being set and new cs_c==0: bit_count<=bit_count+1, wrapping from 2^CNT_W-1 to 0.
  - else: hold.
- bit_count holds its value while cs_c=1 and after cs_rise, until the next cs_fall.
- mosi has no strobes; only mosi_c is produced.

Optional Feature:
- Macro: SPI_COND_FILTER_EN.
- Defined: glitch filter as above; latency WAIT+2.
- Undefined:
  - No filter counters.
  - Each edge cond<=sync2 unconditionally, with strobes on any change.
  - Latency fixed at 3 edges, identical to WAIT=1.
  - WAIT is ignored.
  - Glitches of one clk cycle or longer pass through.

Test Plan:
- Reset, then hold raw pins idle (sclk_raw=0, cs_raw=1, mosi_raw=0) -> sclk_c=0, cs_c=1, mosi_c=0, no strobes, bit_count=0.
- WAIT=3, filter on; sclk_raw 0->1 and held -> sclk_c rises at edge 5 after the change; sclk_rise high for exactly 1 cycle; sclk_fall stays 0.
- WAIT=3, filter on; sclk_raw high for 2 clk cycles then low -> sclk_c stays 0, no strobes. Repeat with a 3-cycle pulse -> one sclk_rise, then one sclk_fall.
- cs_raw low; 8 sclk pulses, each 6 clk high / 6 clk low; then cs_raw high -> one cs_fall, 8 sclk_rise and 8 sclk_fall strobes, bit_count=8 after the 8th rise, then cs_rise with bit_count holding 8.
- Raw cs falls and sclk rises in the same clk cycle -> cs_fall and sclk_rise strobe together, bit_count=0. Also drive 17 rises with CNT_W=4 -> bit_count=1 (wrap).
- Assert reset mid-frame at bit_count=5, sclk_c=1 -> next edge: cs_c=1, sclk_c=0, bit_count=0, no strobes. Repeat the glitch test with the macro undefined -> a 2-cycle glitch produces rise and fall strobes.

Source files
------------

// File: rtl/spi_pin_conditioner.sv
// spi_pin_conditioner
//   Front end of the SPI memory. Brings the raw SPI pins into the clk domain
//   through two-flop synchronizers. Each channel then passes through an
//   optional glitch filter. Produces clean levels, one-cycle edge strobes for
//   sclk and cs, and a per-frame count of sclk rising edges.
//
//   Build option: define SPI_COND_FILTER_EN to enable the glitch filter.
//     Filter enabled:  a synchronized level must differ from the conditioned
//                      level on WAIT consecutive edges before it is accepted.
//                      The latency from a raw change to cond is WAIT+2 edges.
//     Filter disabled: the conditioned level follows the synchronizer
//                      directly. The latency is 3 edges and WAIT is ignored.
//
// Parameters
//   WAIT   consecutive differing samples required, 1..255 (filter builds only)
//   CNT_W  width of bit_count; the count wraps modulo 2^CNT_W
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   sclk_raw   asynchronous SPI clock pin
//   cs_raw     asynchronous chip select pin, active low
//   mosi_raw   asynchronous MOSI pin
//   sclk_c     conditioned sclk level       (reset 0)
//   cs_c       conditioned cs level         (reset 1)
//   mosi_c     conditioned mosi level       (reset 0)
//   sclk_rise  one-cycle strobe, sclk_c 0->1
//   sclk_fall  one-cycle strobe, sclk_c 1->0
//   cs_fall    one-cycle strobe, frame start
//   cs_rise    one-cycle strobe, frame end
//   bit_count  sclk rising edges seen since the last cs_fall

module spi_pin_conditioner #(
    parameter int WAIT  = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_raw,
    input  logic             cs_raw,
    input  logic             mosi_raw,
    output logic             sclk_c,
    output logic             cs_c,
    output logic             mosi_c,
    output logic             sclk_rise,
    output logic             sclk_fall,
    output logic             cs_fall,
    output logic             cs_rise,
    output logic [CNT_W-1:0] bit_count
);

    // Channel order inside the packed vectors: 0 = sclk, 1 = cs, 2 = mosi.
    localparam int         NCH  = 3;
    localparam logic [2:0] IDLE = 3'b010;

    if (WAIT < 1 || WAIT > 255) begin : g_bad_wait
        $error("spi_pin_conditioner: WAIT must be in 1..255");
    end

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] cond;
    logic [NCH-1:0] cond_d;

    assign raw = {mosi_raw, cs_raw, sclk_raw};

    // The synchronizers reset to the idle levels. This keeps the first
    // samples after reset from looking like a change.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
            cond  <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cond  <= cond_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef SPI_COND_FILTER_EN
        localparam logic [7:0] WAIT_M1 = 8'(WAIT - 1);

        logic [7:0] cnt;
        logic [7:0] cnt_d;
        logic       cond_nx;

        // cnt counts consecutive edges on which sync2 disagrees with cond.
        // Any agreeing sample restarts the count, so glitches shorter than
        // WAIT samples are discarded.
        always_comb begin
            cond_nx = cond[i];
            cnt_d   = cnt;
            if (sync2[i] == cond[i]) begin
                cnt_d = '0;
            end else if (cnt == WAIT_M1) begin
                cond_nx = sync2[i];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) cnt <= '0;
            else       cnt <= cnt_d;
        end

        assign cond_d[i] = cond_nx;
`else
        assign cond_d[i] = sync2[i];
`endif
    end

    // The strobes are derived from the level that is being loaded this edge.
    // Each strobe is therefore high during the first cycle cond shows the new
    // value.
    logic sclk_rise_d;
    logic sclk_fall_d;
    logic cs_fall_d;
    logic cs_rise_d;

    assign sclk_rise_d =  cond_d[0] & ~cond[0];
    assign sclk_fall_d = ~cond_d[0] &  cond[0];
    assign cs_fall_d   = ~cond_d[1] &  cond[1];
    assign cs_rise_d   =  cond_d[1] & ~cond[1];

    // Reset takes priority over everything else. A cs 0->1 caused by reset
    // produces no strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            bit_count <= '0;
        end else begin
            sclk_rise <= sclk_rise_d;
            sclk_fall <= sclk_fall_d;
            cs_fall   <= cs_fall_d;
            cs_rise   <= cs_rise_d;
            // A frame start clears the count. If an sclk rise arrives in the
            // same edge as the frame start, that rise is not counted.
            if (cs_fall_d)
                bit_count <= '0;
            else if (sclk_rise_d && !cond_d[1])
                bit_count <= bit_count + CNT_W'(1);
        end
    end

    assign sclk_c = cond[0];
    assign cs_c   = cond[1];
    assign mosi_c = cond[2];

endmodule

// File: tb/tb_spi_pin_conditioner.sv
module tb_spi_pin_conditioner;
    localparam int WAIT  = 3;
    localparam int CNT_W = 4;
`ifdef SPI_COND_FILTER_EN
    localparam int WE   = WAIT;
    localparam bit FILT = 1'b1;
`else
    localparam int WE   = 1;
    localparam bit FILT = 1'b0;
`endif

    logic clk, reset, sclk_raw, cs_raw, mosi_raw;
    logic sclk_c, cs_c, mosi_c, sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [CNT_W-1:0] bit_count;

    spi_pin_conditioner #(.WAIT(WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sclk_raw(sclk_raw), .cs_raw(cs_raw),
        .mosi_raw(mosi_raw), .sclk_c(sclk_c), .cs_c(cs_c), .mosi_c(mosi_c),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall),
        .cs_rise(cs_rise), .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;
    int n_sr = 0, n_sf = 0, n_cf = 0, n_cr = 0;

    // Reference model. hist[c][0] holds the raw value sampled at this edge,
    // and hist[c][k] holds the value sampled k edges earlier. A level reaches
    // the filter two edges after it is sampled. cond flips when the WE
    // samples that reach the filter up to this edge all oppose it.
    logic [WE+1:0]    hist [3];
    logic [2:0]       m_cond;
    logic             m_sr, m_sf, m_cf, m_cr;
    logic [CNT_W-1:0] m_bc;

    task automatic model_update();
        logic [2:0] r;
        logic [2:0] nc;
        r  = {mosi_raw, cs_raw, sclk_raw};
        nc = m_cond;
        if (reset) begin
            m_cond = 3'b010;
            for (int c = 0; c < 3; c++) hist[c] = {(WE+2){m_cond[c]}};
            {m_sr, m_sf, m_cf, m_cr} = 4'b0;
            m_bc = '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                hist[c] = {hist[c][WE:0], r[c]};
                if (hist[c][WE+1:2] == {WE{~m_cond[c]}}) nc[c] = ~m_cond[c];
            end
            m_sr = nc[0] & ~m_cond[0];
            m_sf = ~nc[0] & m_cond[0];
            m_cf = ~nc[1] & m_cond[1];
            m_cr = nc[1] & ~m_cond[1];
            if (m_cf) m_bc = '0;
            else if (m_sr && !nc[1]) m_bc = m_bc + 1'b1;
            m_cond = nc;
        end
    endtask

    task automatic compare();
        logic [6:0] got, exp;
        got = {sclk_c, cs_c, mosi_c, sclk_rise, sclk_fall, cs_fall, cs_rise};
        exp = {m_cond[0], m_cond[1], m_cond[2], m_sr, m_sf, m_cf, m_cr};
        vecs++;
        if (got !== exp || bit_count !== m_bc) begin
            miss++;
            $display("FAIL cycle %0d outputs: got lvl/strb=%b bc=%0d, expected %b bc=%0d",
                     cyc, got, bit_count, exp, m_bc);
        end
        n_sr += int'(sclk_rise); n_sf += int'(sclk_fall);
        n_cf += int'(cs_fall);   n_cr += int'(cs_rise);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        compare();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        n_sr = 0; n_sf = 0; n_cf = 0; n_cr = 0;
    endtask

    task automatic pulse();
        sclk_raw = 1'b1; repeat (6) step();
        sclk_raw = 1'b0; repeat (6) step();
    endtask

    initial begin
        int n;
        int thr;
        reset = 1'b1; sclk_raw = 1'b0; cs_raw = 1'b1; mosi_raw = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        chk("reset sclk_c", int'(sclk_c), 0);
        chk("reset cs_c", int'(cs_c), 1);
        chk("reset mosi_c", int'(mosi_c), 0);
        chk("reset strobes", int'({sclk_rise, sclk_fall, cs_fall, cs_rise}), 0);
        chk("reset bit_count", int'(bit_count), 0);

        // Latency of a held sclk rise.
        clr();
        sclk_raw = 1'b1;
        n = 0;
        do begin step(); n++; end while (!sclk_c && n < 20);
        chk("sclk latency", n, FILT ? 5 : 3);
        repeat (10) step();
        chk("held rise count", n_sr, 1);
        chk("held fall count", n_sf, 0);
        sclk_raw = 1'b0; repeat (10) step();

        // A 2-cycle glitch is rejected only when the filter is enabled.
        clr();
        sclk_raw = 1'b1; repeat (2) step();
        sclk_raw = 1'b0; repeat (12) step();
        chk("2cyc glitch rises", n_sr, FILT ? 0 : 1);
        chk("2cyc glitch falls", n_sf, FILT ? 0 : 1);
        chk("2cyc glitch sclk_c", int'(sclk_c), 0);

        // A 3-cycle pulse passes through.
        clr();
        sclk_raw = 1'b1; repeat (3) step();
        sclk_raw = 1'b0; repeat (12) step();
        chk("3cyc pulse rises", n_sr, 1);
        chk("3cyc pulse falls", n_sf, 1);

        // An 8-bit frame.
        clr();
        cs_raw = 1'b0; repeat (10) step();
        repeat (8) pulse();
        repeat (4) step();
        chk("frame bit_count", int'(bit_count), 8);
        cs_raw = 1'b1; repeat (10) step();
        chk("frame cs_fall", n_cf, 1);
        chk("frame sclk_rise", n_sr, 8);
        chk("frame sclk_fall", n_sf, 8);
        chk("frame cs_rise", n_cr, 1);
        chk("frame bit_count hold", int'(bit_count), 8);

        // cs and sclk change together. The sclk rise is not counted.
        cs_raw = 1'b0; sclk_raw = 1'b1;
        n = 0;
        do begin step(); n++; end while (cs_c && n < 20);
        chk("simul cs_fall", int'(cs_fall), 1);
        chk("simul sclk_rise", int'(sclk_rise), 1);
        chk("simul bit_count", int'(bit_count), 0);
        sclk_raw = 1'b0; repeat (8) step();
        repeat (17) pulse();
        chk("wrap bit_count", int'(bit_count), 1);

        // Reset in the middle of a frame, with bit_count=5 and sclk high.
        cs_raw = 1'b1; repeat (10) step();
        cs_raw = 1'b0; repeat (10) step();
        repeat (4) pulse();
        sclk_raw = 1'b1; repeat (10) step();
        chk("midframe pre bit_count", int'(bit_count), 5);
        chk("midframe pre sclk_c", int'(sclk_c), 1);
        reset = 1'b1; step();
        chk("midframe cs_c", int'(cs_c), 1);
        chk("midframe sclk_c", int'(sclk_c), 0);
        chk("midframe bit_count", int'(bit_count), 0);
        chk("midframe strobes", int'({sclk_rise, sclk_fall, cs_fall, cs_rise}), 0);
        reset = 1'b0; cs_raw = 1'b1; sclk_raw = 1'b0;
        repeat (10) step();

        // Randomized traffic, checked against the model on every cycle.
        thr = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) thr = (i / 200) % 3 == 0 ? 5 : ((i / 200) % 3 == 1 ? 25 : 60);
            if ($urandom_range(0, 99) < thr) sclk_raw = ~sclk_raw;
            if ($urandom_range(0, 99) < thr / 4) cs_raw = ~cs_raw;
            if ($urandom_range(0, 99) < thr) mosi_raw = ~mosi_raw;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
